// File: rtl/i2c_addr_route_ctrl_if.sv
// Merged I2C bus levels plus routing/status outputs of the address router.
// The slave modport is the router's view; master is the bus/top-level view.
interface i2c_addr_route_ctrl_if;
    logic       scl_di;
    logic       sda_di;
    logic       passthrough_enable;
    logic       pass_en;
    logic       local_sel;
    logic [7:0] addr_byte;
    logic       addr_valid;
    logic       bus_busy;
    logic       timeout;

    modport slave (
        input  scl_di, sda_di, passthrough_enable,
        output pass_en, local_sel, addr_byte, addr_valid, bus_busy, timeout
    );

    modport master (
        output scl_di, sda_di, passthrough_enable,
        input  pass_en, local_sel, addr_byte, addr_valid, bus_busy, timeout
    );
endinterface

// File: rtl/i2c_addr_route_ctrl.sv
// I2C interception sequencer: decodes START/address/STOP on the merged bus and
// decides whether the peripheral passthrough stays open for each transaction.
module i2c_addr_route_ctrl #(
    parameter logic [6:0]  LOCAL_ADDR     = 7'h42,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 24000000
) (
    input  logic                   ICE_CLK,
    input  logic                   rst_n,
    i2c_addr_route_ctrl_if.slave   bus
);

    localparam int unsigned FCW = 4;
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_PASS,
        ST_LOCAL
    } state_t;

    logic           scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic           sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic [FCW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic           scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic           scl_p_q, scl_p_d, sda_p_q, sda_p_d;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           match_q, match_d;
    logic           ack_rise_q, ack_rise_d;
    logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic           pass_en_q, pass_en_d;
    logic           local_sel_q, local_sel_d;
    logic [7:0]     addr_byte_q, addr_byte_d;
    logic           addr_valid_q, addr_valid_d;
    logic           bus_busy_q, bus_busy_d;
    logic           timeout_q, timeout_d;

    logic           start_c, stop_c, scl_rise_c, scl_fall_c, tmo_hit_c;
    logic [7:0]     byte_c;

    // Synchronizers and per-line glitch filters.
    always_comb begin
        scl_s1_d  = bus.scl_di;
        scl_s2_d  = scl_s1_q;
        sda_s1_d  = bus.sda_di;
        sda_s2_d  = sda_s1_q;
        scl_f_d   = scl_f_q;
        sda_f_d   = sda_f_q;
        scl_cnt_d = '0;
        sda_cnt_d = '0;
        scl_p_d   = scl_f_q;
        sda_p_d   = sda_f_q;
        if (scl_s2_q != scl_f_q) begin
            if (scl_cnt_q == FCW'(FILTER_LEN - 1)) scl_f_d = scl_s2_q;
            else                                   scl_cnt_d = scl_cnt_q + FCW'(1);
        end
        if (sda_s2_q != sda_f_q) begin
            if (sda_cnt_q == FCW'(FILTER_LEN - 1)) sda_f_d = sda_s2_q;
            else                                   sda_cnt_d = sda_cnt_q + FCW'(1);
        end
    end

    assign start_c    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
    assign stop_c     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
    assign scl_rise_c = scl_f_q & ~scl_p_q;
    assign scl_fall_c = ~scl_f_q & scl_p_q;
    assign tmo_hit_c  = (tmo_cnt_q == TW'(TIMEOUT_CYCLES));
    assign byte_c     = {shift_q[6:0], sda_f_q};

    // Transaction sequencer; bus conditions beat the timeout, which beats SCL edges.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        match_d      = match_q;
        ack_rise_d   = ack_rise_q;
        addr_byte_d  = addr_byte_q;
        addr_valid_d = 1'b0;
        timeout_d    = 1'b0;

        if (state_q == ST_IDLE || start_c || stop_c || scl_rise_c || scl_fall_c)
            tmo_cnt_d = '0;
        else if (!tmo_hit_c)
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        else
            tmo_cnt_d = tmo_cnt_q;

        if (start_c) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = '0;
            shift_d    = '0;
            match_d    = 1'b0;
            ack_rise_d = 1'b0;
        end else if (stop_c) begin
            state_d = ST_IDLE;
        end else if (state_q != ST_IDLE && tmo_hit_c) begin
            state_d   = ST_IDLE;
            timeout_d = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        shift_d = byte_c;
                        if (bit_cnt_q == 3'd7) begin
                            addr_byte_d  = byte_c;
                            addr_valid_d = 1'b1;
                            match_d      = (byte_c[7:1] == LOCAL_ADDR);
                            ack_rise_d   = 1'b0;
                            state_d      = ST_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (scl_rise_c)
                        ack_rise_d = 1'b1;
                    else if (scl_fall_c && ack_rise_q)
                        state_d = match_q ? ST_LOCAL : ST_PASS;
                end
                default: ;
            endcase
        end

        // Outputs follow the next state so they switch on the same edge as the state.
        pass_en_d   = bus.passthrough_enable & (state_d != ST_LOCAL);
        local_sel_d = (state_d == ST_LOCAL);
        bus_busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge ICE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q     <= 1'b1;
            scl_s2_q     <= 1'b1;
            sda_s1_q     <= 1'b1;
            sda_s2_q     <= 1'b1;
            scl_cnt_q    <= '0;
            sda_cnt_q    <= '0;
            scl_f_q      <= 1'b1;
            sda_f_q      <= 1'b1;
            scl_p_q      <= 1'b1;
            sda_p_q      <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            match_q      <= 1'b0;
            ack_rise_q   <= 1'b0;
            tmo_cnt_q    <= '0;
            pass_en_q    <= 1'b0;
            local_sel_q  <= 1'b0;
            addr_byte_q  <= 8'h00;
            addr_valid_q <= 1'b0;
            bus_busy_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            scl_s1_q     <= scl_s1_d;
            scl_s2_q     <= scl_s2_d;
            sda_s1_q     <= sda_s1_d;
            sda_s2_q     <= sda_s2_d;
            scl_cnt_q    <= scl_cnt_d;
            sda_cnt_q    <= sda_cnt_d;
            scl_f_q      <= scl_f_d;
            sda_f_q      <= sda_f_d;
            scl_p_q      <= scl_p_d;
            sda_p_q      <= sda_p_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            match_q      <= match_d;
            ack_rise_q   <= ack_rise_d;
            tmo_cnt_q    <= tmo_cnt_d;
            pass_en_q    <= pass_en_d;
            local_sel_q  <= local_sel_d;
            addr_byte_q  <= addr_byte_d;
            addr_valid_q <= addr_valid_d;
            bus_busy_q   <= bus_busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.pass_en    = pass_en_q;
    assign bus.local_sel  = local_sel_q;
    assign bus.addr_byte  = addr_byte_q;
    assign bus.addr_valid = addr_valid_q;
    assign bus.bus_busy   = bus_busy_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_addr_route_ctrl.sv
// Bench for i2c_addr_route_ctrl: bit-banged I2C transactions on the merged bus
// checked against a transaction-level routing model.
module tb_i2c_addr_route_ctrl;

    localparam logic [6:0]  TB_LOCAL = 7'h42;
    localparam int unsigned TB_FLEN  = 4;
    localparam int unsigned TB_TMO   = 100;
    localparam int          Q        = 8;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    int          av_cnt      = 0;
    logic [7:0]  last_av     = 8'h00;
    int          local_cnt   = 0;
    int          passlow_cnt = 0;
    int          tmo_cnt     = 0;
    int          busy_cnt    = 0;

    i2c_addr_route_ctrl_if bus_if ();

    i2c_addr_route_ctrl #(
        .LOCAL_ADDR     (TB_LOCAL),
        .FILTER_LEN     (TB_FLEN),
        .TIMEOUT_CYCLES (TB_TMO)
    ) dut (
        .ICE_CLK (clk),
        .rst_n   (rst_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled shortly after each active edge.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            if (bus_if.addr_valid) begin
                av_cnt  = av_cnt + 1;
                last_av = bus_if.addr_byte;
            end
            if (bus_if.local_sel) local_cnt = local_cnt + 1;
            if (!bus_if.pass_en)  passlow_cnt = passlow_cnt + 1;
            if (bus_if.timeout)   tmo_cnt = tmo_cnt + 1;
            if (bus_if.bus_busy)  busy_cnt = busy_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        bus_if.sda_di = 1'b1; cyc(Q);
        bus_if.scl_di = 1'b1; cyc(Q);
        bus_if.sda_di = 1'b0; cyc(Q);
        bus_if.scl_di = 1'b0; cyc(Q);
    endtask

    task automatic i2c_bit(input logic b);
        bus_if.sda_di = b;    cyc(Q);
        bus_if.scl_di = 1'b1; cyc(Q);
        bus_if.scl_di = 1'b0; cyc(Q);
    endtask

    task automatic i2c_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
        i2c_bit(1'b0);
        cyc(Q);
    endtask

    task automatic i2c_stop();
        bus_if.sda_di = 1'b0; cyc(Q);
        bus_if.scl_di = 1'b1; cyc(Q);
        bus_if.sda_di = 1'b1; cyc(2 * Q);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.scl_di = 1'b1;
        bus_if.sda_di = 1'b1;
        bus_if.passthrough_enable = 1'b1;
        cyc(3);
        n_cmp++; if (bus_if.pass_en !== 1'b0) begin $display("FAIL rst_pass_en: got %b expected 0", bus_if.pass_en); n_fail++; end
        n_cmp++; if (bus_if.local_sel !== 1'b0) begin $display("FAIL rst_local_sel: got %b expected 0", bus_if.local_sel); n_fail++; end
        n_cmp++; if (bus_if.addr_byte !== 8'h00) begin $display("FAIL rst_addr_byte: got %h expected 00", bus_if.addr_byte); n_fail++; end
        n_cmp++; if (bus_if.addr_valid !== 1'b0) begin $display("FAIL rst_addr_valid: got %b expected 0", bus_if.addr_valid); n_fail++; end
        n_cmp++; if (bus_if.bus_busy !== 1'b0) begin $display("FAIL rst_bus_busy: got %b expected 0", bus_if.bus_busy); n_fail++; end
        n_cmp++; if (bus_if.timeout !== 1'b0) begin $display("FAIL rst_timeout: got %b expected 0", bus_if.timeout); n_fail++; end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (bus_if.pass_en !== 1'b1) begin $display("FAIL rel_pass_en: got %b expected 1", bus_if.pass_en); n_fail++; end
        n_cmp++; if (bus_if.bus_busy !== 1'b0) begin $display("FAIL rel_bus_busy: got %b expected 0", bus_if.bus_busy); n_fail++; end
        n_cmp++; if (bus_if.local_sel !== 1'b0) begin $display("FAIL rel_local_sel: got %b expected 0", bus_if.local_sel); n_fail++; end
        n_cmp++; if (bus_if.addr_byte !== 8'h00) begin $display("FAIL rel_addr_byte: got %h expected 00", bus_if.addr_byte); n_fail++; end
        cyc(4);
    endtask

    // Full transaction against the routing model: local iff addr[7:1] matches.
    task automatic run_txn(input logic [7:0] a, input int nd, input logic [7:0] d0,
                           input logic pte, input string tag);
        logic exp_local, exp_pass;
        int   av0, loc0, pl0;
        logic [7:0] d;
        exp_local = (a[7:1] == TB_LOCAL);
        exp_pass  = pte & ~exp_local;
        bus_if.passthrough_enable = pte;
        cyc(2);
        av0 = av_cnt; loc0 = local_cnt; pl0 = passlow_cnt;
        i2c_start();
        n_cmp++; if (bus_if.bus_busy !== 1'b1) begin $display("FAIL %s start_busy: got %b expected 1", tag, bus_if.bus_busy); n_fail++; end
        n_cmp++; if (bus_if.pass_en !== pte) begin $display("FAIL %s addr_pass_en: got %b expected %b", tag, bus_if.pass_en, pte); n_fail++; end
        i2c_byte(a);
        n_cmp++; if (av_cnt !== av0 + 1) begin $display("FAIL %s addr_valid_count: got %0d expected %0d", tag, av_cnt - av0, 1); n_fail++; end
        n_cmp++; if (last_av !== a) begin $display("FAIL %s addr_byte: got %h expected %h", tag, last_av, a); n_fail++; end
        n_cmp++; if (bus_if.local_sel !== exp_local) begin $display("FAIL %s local_sel: got %b expected %b", tag, bus_if.local_sel, exp_local); n_fail++; end
        n_cmp++; if (bus_if.pass_en !== exp_pass) begin $display("FAIL %s data_pass_en: got %b expected %b", tag, bus_if.pass_en, exp_pass); n_fail++; end
        for (int k = 0; k < nd; k++) begin
            d = (k == 0) ? d0 : 8'($urandom);
            i2c_byte(d);
            n_cmp++; if (bus_if.local_sel !== exp_local || bus_if.pass_en !== exp_pass) begin
                $display("FAIL %s data%0d route: got local=%b pass=%b expected local=%b pass=%b",
                         tag, k, bus_if.local_sel, bus_if.pass_en, exp_local, exp_pass);
                n_fail++;
            end
        end
        i2c_stop();
        n_cmp++; if (bus_if.bus_busy !== 1'b0) begin $display("FAIL %s stop_busy: got %b expected 0", tag, bus_if.bus_busy); n_fail++; end
        n_cmp++; if (bus_if.pass_en !== pte || bus_if.local_sel !== 1'b0) begin
            $display("FAIL %s idle_route: got pass=%b local=%b expected pass=%b local=0", tag, bus_if.pass_en, bus_if.local_sel, pte); n_fail++;
        end
        n_cmp++; if (av_cnt !== av0 + 1) begin $display("FAIL %s total_addr_valid: got %0d expected 1", tag, av_cnt - av0); n_fail++; end
        n_cmp++; if ((local_cnt != loc0) !== exp_local) begin $display("FAIL %s local_seen: got %b expected %b", tag, local_cnt != loc0, exp_local); n_fail++; end
        if (pte) begin
            n_cmp++; if (passlow_cnt - pl0 !== local_cnt - loc0) begin
                $display("FAIL %s pass_low_cycles: got %0d expected %0d", tag, passlow_cnt - pl0, local_cnt - loc0); n_fail++;
            end
        end
    endtask

    task automatic test_local_write();
        run_txn(8'h84, 1, 8'h10, 1'b1, "local_write");
    endtask

    task automatic test_pass_read();
        run_txn(8'hA1, 2, 8'h5A, 1'b1, "pass_read");
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) a = {TB_LOCAL, 1'($urandom_range(0, 1))};
            else                           a = 8'($urandom);
            run_txn(a, $urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 3) != 0), "random");
        end
    endtask

    task automatic test_repeated_start();
        bus_if.passthrough_enable = 1'b1;
        cyc(2);
        i2c_start();
        i2c_byte(8'h84);
        n_cmp++; if (bus_if.local_sel !== 1'b1 || bus_if.pass_en !== 1'b0) begin
            $display("FAIL rs_local_phase: got local=%b pass=%b expected local=1 pass=0", bus_if.local_sel, bus_if.pass_en); n_fail++;
        end
        i2c_start();
        n_cmp++; if (bus_if.pass_en !== 1'b1 || bus_if.local_sel !== 1'b0 || bus_if.bus_busy !== 1'b1) begin
            $display("FAIL rs_restart: got pass=%b local=%b busy=%b expected 1 0 1", bus_if.pass_en, bus_if.local_sel, bus_if.bus_busy); n_fail++;
        end
        i2c_byte(8'hA0);
        n_cmp++; if (last_av !== 8'hA0) begin $display("FAIL rs_addr_byte: got %h expected a0", last_av); n_fail++; end
        n_cmp++; if (bus_if.pass_en !== 1'b1 || bus_if.local_sel !== 1'b0) begin
            $display("FAIL rs_pass_phase: got pass=%b local=%b expected 1 0", bus_if.pass_en, bus_if.local_sel); n_fail++;
        end
        // Global enable gates pass_en without disturbing the transaction.
        bus_if.passthrough_enable = 1'b0;
        cyc(2);
        n_cmp++; if (bus_if.pass_en !== 1'b0 || bus_if.bus_busy !== 1'b1) begin
            $display("FAIL pte_off: got pass=%b busy=%b expected 0 1", bus_if.pass_en, bus_if.bus_busy); n_fail++;
        end
        bus_if.passthrough_enable = 1'b1;
        cyc(2);
        n_cmp++; if (bus_if.pass_en !== 1'b1 || bus_if.bus_busy !== 1'b1) begin
            $display("FAIL pte_on: got pass=%b busy=%b expected 1 1", bus_if.pass_en, bus_if.bus_busy); n_fail++;
        end
        i2c_stop();
        n_cmp++; if (bus_if.bus_busy !== 1'b0) begin $display("FAIL rs_stop_busy: got %b expected 0", bus_if.bus_busy); n_fail++; end
    endtask

    task automatic test_glitch();
        int b0;
        bus_if.scl_di = 1'b1;
        bus_if.sda_di = 1'b1;
        cyc(20);
        b0 = busy_cnt;
        bus_if.sda_di = 1'b0; cyc(int'(TB_FLEN) - 1);
        bus_if.sda_di = 1'b1; cyc(20);
        n_cmp++; if (busy_cnt !== b0 || bus_if.bus_busy !== 1'b0) begin
            $display("FAIL short_glitch: got busy_cycles=%0d expected 0", busy_cnt - b0); n_fail++;
        end
        bus_if.sda_di = 1'b0; cyc(int'(TB_FLEN));
        bus_if.sda_di = 1'b1; cyc(6);
        n_cmp++; if (busy_cnt == b0) begin
            $display("FAIL long_glitch: got busy_cycles=%0d expected nonzero", busy_cnt - b0); n_fail++;
        end
        cyc(20);
        n_cmp++; if (bus_if.bus_busy !== 1'b0) begin $display("FAIL glitch_stop: got %b expected 0", bus_if.bus_busy); n_fail++; end
    endtask

    task automatic test_timeout();
        int n, t0, lo, hi;
        bus_if.passthrough_enable = 1'b1;
        bus_if.scl_di = 1'b1;
        bus_if.sda_di = 1'b1;
        cyc(20);
        t0 = tmo_cnt;
        lo = int'(TB_TMO) + 2 + int'(TB_FLEN);
        hi = lo + 3;
        bus_if.sda_di = 1'b0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (bus_if.timeout === 1'b1) break;
        end
        n_cmp++; if (n < lo || n > hi) begin $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d", n, lo, hi); n_fail++; end
        n_cmp++; if (bus_if.bus_busy !== 1'b0) begin $display("FAIL timeout_idle: got busy=%b expected 0", bus_if.bus_busy); n_fail++; end
        @(negedge clk);
        n_cmp++; if (bus_if.timeout !== 1'b0) begin $display("FAIL timeout_pulse_width: got %b expected 0", bus_if.timeout); n_fail++; end
        bus_if.sda_di = 1'b1;
        cyc(30);
        n_cmp++; if (tmo_cnt - t0 !== 1 || bus_if.bus_busy !== 1'b0) begin
            $display("FAIL timeout_once: got pulses=%0d busy=%b expected 1 0", tmo_cnt - t0, bus_if.bus_busy); n_fail++;
        end
    endtask

    task automatic test_reset_mid_addr();
        int av0, b0;
        logic [7:0] a;
        a = 8'h84;
        bus_if.passthrough_enable = 1'b1;
        cyc(4);
        i2c_start();
        for (int i = 7; i >= 5; i--) i2c_bit(a[i]);
        n_cmp++; if (bus_if.bus_busy !== 1'b1) begin $display("FAIL mid_addr_busy: got %b expected 1", bus_if.bus_busy); n_fail++; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.pass_en !== 1'b0 || bus_if.bus_busy !== 1'b0 || bus_if.local_sel !== 1'b0 || bus_if.addr_byte !== 8'h00) begin
            $display("FAIL async_reset: got pass=%b busy=%b local=%b addr=%h expected 0 0 0 00",
                     bus_if.pass_en, bus_if.bus_busy, bus_if.local_sel, bus_if.addr_byte); n_fail++;
        end
        cyc(3);
        rst_n = 1'b1;
        av0 = av_cnt; b0 = busy_cnt;
        for (int i = 4; i >= 0; i--) i2c_bit(a[i]);
        i2c_bit(1'b0);
        i2c_stop();
        n_cmp++; if (av_cnt !== av0 || busy_cnt !== b0) begin
            $display("FAIL post_reset_ignore: got addr_valid=%0d busy_cycles=%0d expected 0 0", av_cnt - av0, busy_cnt - b0); n_fail++;
        end
        n_cmp++; if (bus_if.pass_en !== 1'b1 || bus_if.addr_byte !== 8'h00) begin
            $display("FAIL post_reset_state: got pass=%b addr=%h expected 1 00", bus_if.pass_en, bus_if.addr_byte); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_local_write();
        test_pass_read();
        test_repeated_start();
        test_glitch();
        test_random();
        test_timeout();
        test_reset_mid_addr();
        run_txn(8'h85, 1, 8'hFF, 1'b1, "back_to_back");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
